// File: rtl/pixel_window_buf.sv
// Streaming 3x3 window generator with two line buffers.
// Holds each interior window until the convolution stage returns calc_done.
module pixel_window_buf #(
    parameter int IMG_W = 16,
    parameter int IMG_H = 16
) (
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic                  frame_start,
    input  logic                  pixel_valid,
    input  logic [3:0]            pixel_in,
    output logic                  pixel_ready,
    output logic [2:0][2:0][3:0]  pixels,
    output logic                  calc_enable,
    input  logic                  calc_done,
    output logic                  frame_done
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);

    typedef enum logic [1:0] {
        ACCEPT,
        CALC,
        DONE
    } state_t;

    state_t                 state_q, state_d;
    logic [IMG_W-1:0][3:0]  lb1_q, lb1_d;
    logic [IMG_W-1:0][3:0]  lb2_q, lb2_d;
    logic [2:0][2:0][3:0]   win_q, win_d;
    logic [CW-1:0]          col_q, col_d;
    logic [RW-1:0]          row_q, row_d;
    logic                   last_q, last_d;
    logic                   calc_en_q, calc_en_d;
    logic                   fdone_q, fdone_d;

    logic accept;
    logic col_last;
    logic row_last;
    logic is_win;

    always_comb begin
        state_d   = state_q;
        lb1_d     = lb1_q;
        lb2_d     = lb2_q;
        win_d     = win_q;
        col_d     = col_q;
        row_d     = row_q;
        last_d    = last_q;
        accept    = pixel_valid && (state_q == ACCEPT);
        col_last  = (col_q == CW'(IMG_W - 1));
        row_last  = (row_q == RW'(IMG_H - 1));
        is_win    = (row_q >= RW'(2)) && (col_q >= CW'(2));

        if (accept) begin
            for (int r = 0; r < 3; r++) begin
                win_d[r][0] = win_q[r][1];
                win_d[r][1] = win_q[r][2];
            end
            win_d[2][2]  = pixel_in;
            win_d[1][2]  = lb1_q[col_q];
            win_d[0][2]  = lb2_q[col_q];
            lb2_d[col_q] = lb1_q[col_q];
            lb1_d[col_q] = pixel_in;
            if (col_last) begin
                col_d = '0;
                row_d = row_last ? '0 : row_q + RW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end
        end

        unique case (state_q)
            ACCEPT: begin
                if (accept && is_win) begin
                    state_d = CALC;
                    last_d  = row_last && col_last;
                end
            end
            CALC: begin
                if (calc_done) begin
                    state_d = last_q ? DONE : ACCEPT;
                end
            end
            DONE: begin
                state_d = ACCEPT;
                row_d   = '0;
                col_d   = '0;
            end
            default: state_d = ACCEPT;
        endcase

        // A pixel arriving with frame_start is stored as column 0 of row 0.
        if (frame_start) begin
            state_d = ACCEPT;
            win_d   = '0;
            last_d  = 1'b0;
            row_d   = '0;
            col_d   = accept ? CW'(1) : '0;
            lb1_d   = lb1_q;
            lb2_d   = lb2_q;
            if (accept) begin
                lb2_d[0] = lb1_q[0];
                lb1_d[0] = pixel_in;
            end
        end

        calc_en_d = (state_d == CALC);
        fdone_d   = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q   <= ACCEPT;
            lb1_q     <= '0;
            lb2_q     <= '0;
            win_q     <= '0;
            col_q     <= '0;
            row_q     <= '0;
            last_q    <= 1'b0;
            calc_en_q <= 1'b0;
            fdone_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            lb1_q     <= lb1_d;
            lb2_q     <= lb2_d;
            win_q     <= win_d;
            col_q     <= col_d;
            row_q     <= row_d;
            last_q    <= last_d;
            calc_en_q <= calc_en_d;
            fdone_q   <= fdone_d;
        end
    end

    assign pixel_ready = (state_q == ACCEPT);
    assign pixels      = win_q;
    assign calc_enable = calc_en_q;
    assign frame_done  = fdone_q;

endmodule

// File: tb/tb_pixel_window_buf.sv
// Directed bench for pixel_window_buf on a 4x4 image.
// Expected windows are built from the image formula img(r,c)=4r+c.
module tb_pixel_window_buf;

    typedef logic [2:0][2:0][3:0] win_t;

    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic       frame_start = 1'b0;
    logic       pixel_valid = 1'b0;
    logic [3:0] pixel_in = 4'd0;
    logic       calc_done = 1'b0;
    logic       pixel_ready;
    win_t       pixels;
    logic       calc_enable;
    logic       frame_done;

    int n_vec = 0;
    int n_bad = 0;
    int n_acc = 0;
    int n_fd  = 0;

    pixel_window_buf #(
        .IMG_W(4),
        .IMG_H(4)
    ) dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .frame_start(frame_start),
        .pixel_valid(pixel_valid),
        .pixel_in   (pixel_in),
        .pixel_ready(pixel_ready),
        .pixels     (pixels),
        .calc_enable(calc_enable),
        .calc_done  (calc_done),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [35:0] got,
                       input logic [35:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // base = img value at window corner; inv selects 15-img
    function automatic win_t mkwin(input int base, input bit inv);
        win_t w;
        int   v;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                v = base + 4 * r + c;
                w[r][c] = inv ? 4'(15 - v) : 4'(v);
            end
        end
        return w;
    endfunction

    task automatic tick();
        logic acc;
        logic ce;
        win_t p;
        acc = pixel_valid && pixel_ready;
        ce  = calc_enable;
        p   = pixels;
        @(posedge clk);
        #1;
        if (acc) n_acc++;
        if (frame_done) n_fd++;
        if (ce) chk("no_accept_in_calc", 36'(acc), 36'd0);
        if (ce && calc_enable) chk("hold_pixels", pixels, p);
    endtask

    task automatic feed(input logic [3:0] v);
        pixel_in    = v;
        pixel_valid = 1'b1;
        tick();
    endtask

    task automatic release_win();
        calc_done = 1'b1;
        tick();
        calc_done = 1'b0;
    endtask

    initial begin
        #12;
        chk("rst_ready", 36'(pixel_ready), 36'd1);
        chk("rst_ce", 36'(calc_enable), 36'd0);
        chk("rst_fd", 36'(frame_done), 36'd0);
        chk("rst_pixels", pixels, 36'd0);
        n_rst = 1'b1;

        for (int k = 0; k < 10; k++) feed(4'(k));
        chk("no_early_win", 36'(calc_enable), 36'd0);
        feed(4'd10);
        chk("win22_ce", 36'(calc_enable), 36'd1);
        chk("win22_pix", pixels, mkwin(0, 0));
        chk("win22_ready", 36'(pixel_ready), 36'd0);

        pixel_in = 4'd11;
        repeat (9) tick();
        chk("bp_ready", 36'(pixel_ready), 36'd0);
        chk("bp_ce", 36'(calc_enable), 36'd1);
        release_win();
        chk("rel_ce", 36'(calc_enable), 36'd0);
        chk("rel_ready", 36'(pixel_ready), 36'd1);
        tick();
        chk("win23_ce", 36'(calc_enable), 36'd1);
        chk("win23_pix", pixels, mkwin(1, 0));

        pixel_in = 4'd12;
        repeat (9) tick();
        release_win();
        calc_done = 1'b1;
        tick();
        chk("stray_ce", 36'(calc_enable), 36'd0);
        chk("stray_ready", 36'(pixel_ready), 36'd1);
        pixel_in = 4'd13;
        tick();
        chk("stray2_ce", 36'(calc_enable), 36'd0);
        calc_done = 1'b0;
        pixel_in = 4'd14;
        tick();
        chk("win32_pix", pixels, mkwin(4, 0));
        repeat (3) tick();
        chk("win32_waits", 36'(calc_enable), 36'd1);

        pixel_in = 4'd15;
        repeat (6) tick();
        release_win();
        tick();
        chk("win33_ce", 36'(calc_enable), 36'd1);
        chk("win33_pix", pixels, mkwin(5, 0));
        pixel_valid = 1'b0;
        repeat (9) tick();
        release_win();
        chk("fd_high", 36'(frame_done), 36'd1);
        chk("fd_ready", 36'(pixel_ready), 36'd0);
        chk("fd_ce", 36'(calc_enable), 36'd0);
        tick();
        chk("fd_low", 36'(frame_done), 36'd0);
        chk("post_ready", 36'(pixel_ready), 36'd1);
        repeat (2) tick();
        chk("fd_count", 36'(n_fd), 36'd1);
        chk("accept_count", 36'(n_acc), 36'd16);

        for (int k = 0; k < 11; k++) feed(4'(k));
        chk("f2_win22_pix", pixels, mkwin(0, 0));
        pixel_valid = 1'b0;
        release_win();
        feed(4'd11);
        chk("f2_win23_ce", 36'(calc_enable), 36'd1);
        pixel_valid = 1'b0;
        frame_start = 1'b1;
        tick();
        chk("abort_ce", 36'(calc_enable), 36'd0);
        chk("abort_pix", pixels, 36'd0);
        chk("abort_ready", 36'(pixel_ready), 36'd1);
        feed(4'd15);
        frame_start = 1'b0;
        chk("fs_px_ce", 36'(calc_enable), 36'd0);
        for (int k = 1; k < 11; k++) feed(4'(15 - k));
        chk("inv_win_ce", 36'(calc_enable), 36'd1);
        chk("inv_win_pix", pixels, mkwin(0, 1));

        pixel_valid = 1'b0;
        #1;
        n_rst = 1'b0;
        #1;
        chk("arst_ready", 36'(pixel_ready), 36'd1);
        chk("arst_ce", 36'(calc_enable), 36'd0);
        chk("arst_fd", 36'(frame_done), 36'd0);
        chk("arst_pix", pixels, 36'd0);
        #2;
        n_rst = 1'b1;
        for (int k = 0; k < 10; k++) feed(4'(k));
        chk("rs_no_early", 36'(calc_enable), 36'd0);
        feed(4'd10);
        chk("rs_win_ce", 36'(calc_enable), 36'd1);
        chk("rs_win_pix", pixels, mkwin(0, 0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
